// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential binary to packed-BCD converter (double dabble)
//
// Converts a W-bit unsigned operand into D packed BCD digits, one operand bit
// per clock, MSB first. A result takes W cycles from the accepting edge.
//
// Ports:
//   clock    - system clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   start    - conversion request, sampled only while idle
//   bin_in   - W-bit unsigned operand, captured on the accepting edge
//   busy     - high while a conversion is in progress
//   done     - one-cycle registered pulse when bcd_out/overflow update
//   bcd_out  - D packed BCD digits, digit 0 in bits [3:0], held between results
//   overflow - result did not fit in D digits, held with bcd_out
module bin_to_bcd_seq #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin_in,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd_out,
  output logic           overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [5:0] LAST = 6'(W - 1);

  state_t         r_state, w_state_nxt;
  logic [4*D-1:0] r_work, w_work_nxt;
  logic [W-1:0]   r_oper, w_oper_nxt;
  logic [5:0]     r_cnt, w_cnt_nxt;
  logic           r_ovf_acc, w_ovf_acc_nxt;
  logic [4*D-1:0] r_bcd, w_bcd_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic           r_done, w_done_nxt;

  logic [4*D-1:0] w_adj;
  logic [4*D-1:0] w_shifted;
  logic           w_carry;
  logic [4*D-1:0] w_blanked;
  logic           w_lead;

  // Add-3 correction so that the following left shift carries correctly
  // between decimal digits.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < D; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is lost from the D-digit result; it is the
  // only sign that the value exceeded 10^D - 1.
  assign w_carry   = w_adj[4*D-1];
  assign w_shifted = {w_adj[4*D-2:0], r_oper[W-1]};

  // Leading-zero blanking works on the final digits only; digit 0 always
  // stays visible so a zero result shows a single "0".
  always_comb begin
    w_blanked = w_shifted;
    w_lead    = 1'b1;
    if (BLANK_LZ) begin
      for (int i = D - 1; i >= 1; i--) begin
        if (w_lead && (w_shifted[4*i +: 4] == 4'd0)) begin
          w_blanked[4*i +: 4] = 4'hF;
        end else begin
          w_lead = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_oper_nxt    = r_oper;
    w_cnt_nxt     = r_cnt;
    w_ovf_acc_nxt = r_ovf_acc;
    w_bcd_nxt     = r_bcd;
    w_ovf_nxt     = r_ovf;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_oper_nxt    = bin_in;
          w_work_nxt    = '0;
          w_cnt_nxt     = '0;
          w_ovf_acc_nxt = 1'b0;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        w_work_nxt    = w_shifted;
        w_oper_nxt    = {r_oper[W-2:0], 1'b0};
        w_cnt_nxt     = r_cnt + 6'd1;
        w_ovf_acc_nxt = r_ovf_acc | w_carry;
        if (r_cnt == LAST) begin
          w_bcd_nxt   = w_blanked;
          w_ovf_nxt   = r_ovf_acc | w_carry;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_oper    <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_oper    <= w_oper_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovf_acc <= w_ovf_acc_nxt;
      r_bcd     <= w_bcd_nxt;
      r_ovf     <= w_ovf_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  localparam int W = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  bin_in = '0;

  logic          busy0, done0, ovf0;
  logic [31:0]   bcd0;
  logic          busy1, done1, ovf1;
  logic [31:0]   bcd1;
  logic          busy2, done2, ovf2;
  logic [15:0]   bcd2;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.W(W), .D(8), .BLANK_LZ(1'b0)) u_plain (
    .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0));

  bin_to_bcd_seq #(.W(W), .D(8), .BLANK_LZ(1'b1)) u_blank (
    .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1));

  bin_to_bcd_seq #(.W(W), .D(4), .BLANK_LZ(1'b0)) u_d4 (
    .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));

  typedef struct {
    int          due;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] b2;
    logic        o2;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int next_acc = 0;
  int last_acc = -1000;

  logic [31:0] h0 = '0, h1 = '0, h2 = '0;
  logic        ho2 = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digits of v mod 10^d; a digit above the most significant nonzero
  // digit is blanked when requested (digit 0 never).
  function automatic logic [31:0] bcd_of(input longint v, input int d, input bit blank);
    logic [31:0] r = '0;
    longint m = v % pow10(d);
    longint x = m;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
      if (blank && i > 0 && m < pow10(i)) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic accept(input logic [W-1:0] v, input int edge_no);
    exp_t e;
    e.due = edge_no + W;
    e.b0  = bcd_of(longint'(v), 8, 1'b0);
    e.b1  = bcd_of(longint'(v), 8, 1'b1);
    e.b2  = bcd_of(longint'(v), 4, 1'b0);
    e.o2  = (longint'(v) >= pow10(4));
    sb.push_back(e);
    last_acc = edge_no;
    next_acc = edge_no + W + 1;
  endtask

  // Inputs for the next rising edge (edge number cyc+1).
  task automatic drive(input logic rst, input logic s, input logic [W-1:0] v);
    @(negedge clock);
    #1;
    reset  = rst;
    start  = s;
    bin_in = v;
    if (!rst) begin
      sb.delete();
      last_acc = -1000;
      next_acc = 0;
      h0 = '0; h1 = '0; h2 = '0; ho2 = 1'b0;
    end else if (s && (cyc + 1 >= next_acc)) begin
      accept(v, cyc + 1);
    end
  endtask

  task automatic convert(input logic [W-1:0] v);
    drive(1'b1, 1'b1, v);
    repeat (W + 2) drive(1'b1, 1'b0, W'($urandom));
  endtask

  initial begin : monitor
    logic done_exp, busy_exp;
    forever begin
      @(negedge clock);
      done_exp = reset && (sb.size() > 0) && (sb[0].due == cyc);
      busy_exp = reset && (cyc >= last_acc) && (cyc <= last_acc + W - 1);
      if (done_exp) begin
        h0  = sb[0].b0;
        h1  = sb[0].b1;
        h2  = sb[0].b2;
        ho2 = sb[0].o2;
        void'(sb.pop_front());
      end
      chk("done_plain", {31'd0, done0}, {31'd0, done_exp});
      chk("done_blank", {31'd0, done1}, {31'd0, done_exp});
      chk("done_d4",    {31'd0, done2}, {31'd0, done_exp});
      chk("busy_plain", {31'd0, busy0}, {31'd0, busy_exp});
      chk("busy_blank", {31'd0, busy1}, {31'd0, busy_exp});
      chk("busy_d4",    {31'd0, busy2}, {31'd0, busy_exp});
      chk("bcd_plain",  bcd0, h0);
      chk("bcd_blank",  bcd1, h1);
      chk("bcd_d4",     {16'd0, bcd2}, h2);
      chk("ovf_plain",  {31'd0, ovf0}, 32'd0);
      chk("ovf_blank",  {31'd0, ovf1}, 32'd0);
      chk("ovf_d4",     {31'd0, ovf2}, {31'd0, ho2});
    end
  end

  initial begin : stimulus
    int gap;
    repeat (3) drive(1'b0, 1'b0, '0);

    // Start on the very first edge after reset release.
    drive(1'b1, 1'b1, 16'd0);
    repeat (W + 2) drive(1'b1, 1'b0, '0);
    convert(16'd65535);
    convert(16'd1234);
    convert(16'd0);

    // Second start three cycles into a conversion is ignored.
    drive(1'b1, 1'b1, 16'd4321);
    drive(1'b1, 1'b0, 16'd1111);
    drive(1'b1, 1'b0, 16'd2222);
    drive(1'b1, 1'b1, 16'd9999);
    repeat (W) drive(1'b1, 1'b0, 16'd5555);

    // Start held high: one conversion every W+1 cycles.
    repeat (4 * (W + 1)) drive(1'b1, 1'b1, W'($urandom));
    repeat (W + 2) drive(1'b1, 1'b0, '0);

    // Reset after five shift edges abandons the conversion.
    drive(1'b1, 1'b1, 16'd50000);
    repeat (5) drive(1'b1, 1'b0, 16'd50000);
    repeat (3) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 16'd7);
    repeat (W + 2) drive(1'b1, 1'b0, '0);

    // D=4 overflow then a value that fits.
    convert(16'd12345);
    convert(16'd9999);
    convert(16'd10000);
    convert(16'd9);
    convert(16'd10);

    // Randomized traffic, including starts while busy.
    repeat (150) begin
      drive(1'b1, 1'b1, W'($urandom));
      gap = $urandom_range(0, 20);
      repeat (gap) drive(1'b1, ($urandom_range(0, 3) == 0), W'($urandom));
    end

    repeat (2 * W + 8) drive(1'b1, 1'b0, '0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters SHALL be, one per line:
- W, 16, width of the binary operand (2..32).
- D, 8, number of BCD digits produced (1..8).
- BLANK_LZ, 0, when 1, leading-zero digits are replaced by 4'hF so the downstream 7-segment decoder renders them dark.

REQ-002 Ports SHALL be, one per line, clock and reset first:
- clock, input, 1, single system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
- start, input, 1, request to convert bin_in; sampled only in IDLE.
- bin_in, input, W, unsigned binary operand; captured on the accepting edge.
- busy, output, 1, high while a conversion is in progress.
- done, output, 1, one-cycle pulse marking that bcd_out and overflow were updated.
- bcd_out, output, 4*D, packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is least significant; held between conversions.
- overflow, output, 1, high when the result did not fit in D digits; held with bcd_out.

Function
REQ-003 The conversion SHALL use sequential shift-add-3 (double dabble), one binary bit per clock, MSB first.
REQ-004 The FSM SHALL have two states, IDLE and SHIFT.
REQ-005 In IDLE with start=1 at edge k, the block SHALL do all of the following:
- load bin_in into the operand shift register;
- clear the D-digit working register, the bit counter and the overflow accumulator;
- enter SHIFT.
REQ-006 Each SHIFT edge SHALL do the following, in order:
- add 3 to every working digit that is >=5;
- shift {working digits, operand} left by one bit;
- increment the bit counter.
REQ-007 The bit shifted out of the top digit during a SHIFT edge SHALL be ORed into the overflow accumulator.
REQ-008 At the W-th SHIFT edge (edge k+W), the block SHALL do all of the following:
- load bcd_out from the final working register, with blanking applied;
- load overflow from the accumulator;
- assert done for exactly one cycle;
- return to IDLE.
REQ-009 Latency SHALL be W clock cycles from the accepting edge to done.
REQ-010 busy SHALL equal (state==SHIFT).
REQ-011 busy SHALL be 1 from edge k through edge k+W-1 and 0 from edge k+W.
REQ-012 start while busy SHALL be ignored, and bin_in changes while busy SHALL have no effect.
REQ-013 start=1 on edge k+W (the completing edge) SHALL be ignored; the earliest next acceptance SHALL be edge k+W+1, giving a minimum issue interval of W+1 cycles.
REQ-014 When overflow=1, bcd_out SHALL equal bin_in mod 10^D in BCD.
REQ-015 With BLANK_LZ=1, every digit above the most significant nonzero digit SHALL be output as 4'hF.
REQ-016 Digit 0 SHALL never be blanked, so value 0 displays a single "0".
REQ-017 Blanking SHALL apply to the stored bcd_out only; internal arithmetic SHALL always use true BCD.
REQ-018 If start is held high continuously, a new conversion SHALL begin every W+1 cycles using bin_in as sampled on each accepting edge.
REQ-019 bcd_out and overflow SHALL change only on a completing edge or on reset.
REQ-020 done SHALL be registered (glitch-free).

Reset
REQ-021 When reset=0, the block SHALL asynchronously force all of the following, regardless of the clock:
- state=IDLE;
- busy=0, done=0;
- bcd_out=0 (not blanked), overflow=0;
- working register, operand register and bit counter = 0.
REQ-022 A conversion in progress when reset asserts SHALL be abandoned; no done pulse SHALL follow reset release.
REQ-023 The first edge after reset deassertion SHALL be able to accept start.

Verification
REQ-024 Directed bench scenarios (W=16, D=8, BLANK_LZ=0 unless noted) SHALL cover:
- bin_in=0, start pulse -> after 16 cycles one done pulse; bcd_out=32'h0000_0000, overflow=0; busy high for exactly 16 cycles.
- bin_in=65535 -> bcd_out=32'h0006_5535, overflow=0, done exactly 16 cycles after the accepting edge.
- BLANK_LZ=1: bin_in=1234 -> bcd_out=32'hFFFF_1234; bin_in=0 -> bcd_out=32'hFFFF_FFF0.
- Start bin_in=4321, then start bin_in=9999 three cycles later -> second start ignored; bcd_out=32'h0000_4321; start held continuously -> done every 17 cycles.
- reset=0 after 5 SHIFT edges of bin_in=50000 -> busy=0, bcd_out=0, no done; after release, start bin_in=7 -> bcd_out=32'h0000_0007.
- D=4: bin_in=12345 -> bcd_out=16'h2345, overflow=1; a following bin_in=9999 -> overflow=0.
